// File: rtl/cv32e40px_x_result_buf.sv
// -----------------------------------------------------------------------------
// cv32e40px_x_result_buf
//
// Buffers coprocessor X-interface results and writes them into the core
// register file on cycles when the core's own WB stage leaves the write port
// free. The dispatcher is told which destination register to clear in its
// scoreboard. If the core keeps the port busy too long, a one-cycle WB stall
// request is raised.
//
// Configuration macro: CV32E40PX_X_RESULT_BYPASS_EN
//   defined   - a result arriving at an empty FIFO with a free RF port is
//               written in the same cycle without being stored, and a full
//               FIFO accepts a new result in the cycle its head pops.
//   undefined - every result is stored first; minimum latency is one cycle.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   x_result_valid_i/ready_o     result handshake from the coprocessor
//   x_result_id_i/data_i/rd_i/we_i  result payload
//   core_wb_we_i                 core WB owns the RF port this cycle
//   rf_we_o/rf_waddr_o/rf_wdata_o   RF write port for X results
//   sb_clr_valid_o/sb_clr_addr_o    scoreboard clear pulse to the dispatcher
//   wb_stall_req_o               one-cycle request to stall core WB
//   last_id_o                    id of the most recently retired entry
//   count_o/empty_o/full_o       FIFO status
// -----------------------------------------------------------------------------
module cv32e40px_x_result_buf #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_LIMIT = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       x_result_valid_i,
    output logic                       x_result_ready_o,
    input  logic [3:0]                 x_result_id_i,
    input  logic [31:0]                x_result_data_i,
    input  logic [4:0]                 x_result_rd_i,
    input  logic                       x_result_we_i,
    input  logic                       core_wb_we_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [31:0]                rf_wdata_o,
    output logic                       sb_clr_valid_o,
    output logic [4:0]                 sb_clr_addr_o,
    output logic                       wb_stall_req_o,
    output logic [3:0]                 last_id_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL} stall_state_e;

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    last_id_q;
    stall_state_e  state_q, state_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    entry_t head, in_ent, wr_ent;
    logic   push, store, pop, bypass, wr_fire, starved;

    assign in_ent  = '{id: x_result_id_i, rd: x_result_rd_i, we: x_result_we_i, data: x_result_data_i};
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o = count_q;

    // Core WB always wins the RF port.
    assign pop     = ~empty_o & ~core_wb_we_i;
    assign starved = ~empty_o & core_wb_we_i;

`ifdef CV32E40PX_X_RESULT_BYPASS_EN
    assign bypass           = empty_o & ~core_wb_we_i & x_result_valid_i;
    assign x_result_ready_o = ~full_o | pop;
`else
    assign bypass           = 1'b0;
    assign x_result_ready_o = ~full_o;
`endif

    assign push    = x_result_valid_i & x_result_ready_o;
    assign store   = push & ~bypass;

    // pop and bypass are mutually exclusive (pop needs a non-empty FIFO).
    assign wr_fire = pop | bypass;
    assign wr_ent  = bypass ? in_ent : head;

    // rd=0 still clears its scoreboard bit but never writes x0.
    assign rf_we_o        = wr_fire & wr_ent.we & (wr_ent.rd != 5'd0);
    assign sb_clr_valid_o = wr_fire & wr_ent.we;
    // Address/data are held at zero when nothing retires so idle outputs are clean.
    assign rf_waddr_o     = wr_fire ? wr_ent.rd   : 5'd0;
    assign rf_wdata_o     = wr_fire ? wr_ent.data : 32'd0;
    assign sb_clr_addr_o  = wr_fire ? wr_ent.rd   : 5'd0;
    assign last_id_o      = last_id_q;
    assign wb_stall_req_o = (state_q == S_STALL);

    // Storage needs no reset: occupancy is governed by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (store) mem_q[wr_ptr_q[AW-1:0]] <= in_ent;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_id_q <= '0;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({store, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_fire) last_id_q <= wr_ent.id;
        end
    end

    // Starvation control: count consecutive cycles the buffered head loses
    // the RF port; past the limit, request a single WB stall cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (starved) begin
                    state_d     = S_WAIT;
                    stall_cnt_d = SW'(1);
                end
            end
            S_WAIT: begin
                if (pop || empty_o) begin
                    state_d = S_IDLE;
                end else if (stall_cnt_q == SW'(STALL_LIMIT)) begin
                    state_d = S_STALL;
                end else if (starved) begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
            end
            S_STALL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
